// File: rtl/nios_mul_pkg.sv
// Shared types and encodings for the NIOS multiply sequencer and its combine stage.
package nios_mul_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS1 = 3'd1,
    CAP1  = 3'd2,
    PASS2 = 3'd3,
    CAP2  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic OP_MUL    = 1'b0;
  localparam logic OP_MULXUU = 1'b1;

  // Products appear this many cycles after cell_en is sampled.
  localparam int CELL_LATENCY = 1;

  function automatic logic [31:0] hi_half(input logic [31:0] w);
    return {16'h0, w[31:16]};
  endfunction

endpackage

// File: rtl/nios_mul_sequencer_if.sv
// Request/response handshake plus the operand/product links to the external 16x16 cell.
interface nios_mul_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        kill;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] cell_src1;
  logic [31:0] cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1;
  logic [31:0] cell_p2;
  logic [31:0] cell_p3;

  modport slave (
    input  req_valid, req_op, req_a, req_b, kill, rsp_ready,
    input  cell_p1, cell_p2, cell_p3,
    output req_ready, rsp_valid, rsp_data, cell_src1, cell_src2, cell_en
  );

  modport master (
    output req_valid, req_op, req_a, req_b, kill, rsp_ready,
    output cell_p1, cell_p2, cell_p3,
    input  req_ready, rsp_valid, rsp_data, cell_src1, cell_src2, cell_en
  );
endinterface

// File: rtl/nios_mul_combine.sv
// Combines four 16x16 partial products into the full 64-bit product.
// Purely combinational; no flow control.
module nios_mul_combine (
  input  logic [31:0] ll,
  input  logic [31:0] lh,
  input  logic [31:0] hl,
  input  logic [31:0] hh,
  output logic [63:0] p
);

  logic [32:0] mid;

  // Cross terms summed at 33 bits so their carry lands in bit 48 of the product.
  always_comb begin
    mid = {1'b0, lh} + {1'b0, hl};
    p   = {hh, ll} + ({31'h0, mid} << 16);
  end

endmodule

// File: rtl/nios_mul_sequencer.sv
// Sequences a 32x32 MUL/MULXUU through an external 16x16 cell; response 3 (MUL) or 5 (MULXUU) cycles after accept.
// Holds the response in DONE until rsp_ready; kill aborts any non-idle operation silently.
module nios_mul_sequencer
  import nios_mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  nios_mul_sequencer_if.slave  bus
);

  state_t      state;
  state_t      next_state;
  logic        accept;
  logic        op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] ll_q;
  logic [31:0] lh_q;
  logic [31:0] hl_q;
  logic [31:0] rsp_data_q;
  logic [31:0] cell_src1_q;
  logic [31:0] cell_src2_q;
  logic        cell_en_q;
  logic [31:0] cmb_ll;
  logic [31:0] cmb_lh;
  logic [31:0] cmb_hl;
  logic [31:0] cmb_hh;
  logic [63:0] product;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          next_state = PASS1;
        end
      end
      PASS1:   next_state = CAP1;
      CAP1:    next_state = (op_q == OP_MULXUU) ? PASS2 : DONE;
      PASS2:   next_state = CAP2;
      CAP2:    next_state = DONE;
      DONE:    if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (bus.kill && state != IDLE) begin
      next_state = IDLE;
    end
  end

  // The low word never needs HH, so the MUL path combines straight off the cell outputs.
  always_comb begin
    cmb_ll = bus.cell_p1;
    cmb_lh = bus.cell_p2;
    cmb_hl = bus.cell_p3;
    cmb_hh = 32'h0;
    if (state == CAP2) begin
      cmb_ll = ll_q;
      cmb_lh = lh_q;
      cmb_hl = hl_q;
      cmb_hh = bus.cell_p1;
    end
  end

  nios_mul_combine u_combine (
    .ll (cmb_ll),
    .lh (cmb_lh),
    .hl (cmb_hl),
    .hh (cmb_hh),
    .p  (product)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q        <= OP_MUL;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      ll_q        <= 32'h0;
      lh_q        <= 32'h0;
      hl_q        <= 32'h0;
      rsp_data_q  <= 32'h0;
      cell_src1_q <= 32'h0;
      cell_src2_q <= 32'h0;
      cell_en_q   <= 1'b0;
    end else begin
      cell_en_q <= (next_state == PASS1) || (next_state == PASS2);
      if (accept) begin
        op_q        <= bus.req_op;
        a_q         <= bus.req_a;
        b_q         <= bus.req_b;
        cell_src1_q <= bus.req_a;
        cell_src2_q <= bus.req_b;
      end
      if (state == CAP1 && !bus.kill) begin
        ll_q <= bus.cell_p1;
        lh_q <= bus.cell_p2;
        hl_q <= bus.cell_p3;
      end
      if (state == CAP1 && next_state == PASS2) begin
        cell_src1_q <= hi_half(a_q);
        cell_src2_q <= hi_half(b_q);
      end
      if (next_state == DONE && state != DONE) begin
        rsp_data_q <= (op_q == OP_MULXUU) ? product[63:32] : product[31:0];
      end
    end
  end

  assign bus.req_ready = (state == IDLE) && reset_n;
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.cell_src1 = cell_src1_q;
  assign bus.cell_src2 = cell_src2_q;
  assign bus.cell_en   = cell_en_q;

endmodule

// File: tb/tb_nios_mul_sequencer.sv
// Scoreboard bench for nios_mul_sequencer with a behavioural 16x16 cell and a 64-bit arithmetic reference.
module tb_nios_mul_sequencer;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  int   en_total;
  logic [31:0] exp_q[$];

  nios_mul_sequencer_if bus();

  nios_mul_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External multiplier cell: registered partial products, one cycle after cell_en.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.cell_p1 <= 32'h0;
      bus.cell_p2 <= 32'h0;
      bus.cell_p3 <= 32'h0;
    end else if (bus.cell_en) begin
      bus.cell_p1 <= 32'(bus.cell_src1[15:0]) * 32'(bus.cell_src2[15:0]);
      bus.cell_p2 <= 32'(bus.cell_src1[15:0]) * 32'(bus.cell_src2[31:16]);
      bus.cell_p3 <= 32'(bus.cell_src1[31:16]) * 32'(bus.cell_src2[15:0]);
    end
  end

  always @(negedge clk) begin
    if (bus.cell_en) en_total <= en_total + 1;
  end

  function automatic logic [31:0] ref_mul(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = 64'(a) * 64'(b);
    return op ? full[63:32] : full[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed response handshake is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && bus.rsp_valid && bus.rsp_ready && !bus.kill) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", bus.rsp_data, 64'hDEAD);
        end else begin
          check("rsp_data", bus.rsp_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.req_ready) check("req_ready_timeout", 0, 1);
  endtask

  task automatic run_req(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit kill_idle);
    int cyc;
    int en_base;
    logic [31:0] d0;
    bus.rsp_ready = (hold == 0);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.kill      = kill_idle;
    exp_q.push_back(ref_mul(op, a, b));
    en_base = en_total;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.kill      = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    bus.req_op    = $urandom_range(0, 1);
    cyc = 1;
    while (!bus.rsp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, op ? 5 : 3);
    check("cell_en_pulses", en_total - en_base, op ? 2 : 1);
    if (hold > 0) begin
      d0 = bus.rsp_data;
      for (int i = 0; i < hold; i++) begin
        check("bp_valid", bus.rsp_valid, 1);
        check("bp_data_stable", bus.rsp_data, d0);
        check("bp_req_ready", bus.req_ready, 0);
        @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("post_rsp_ready", bus.req_ready, 1);
  endtask

  // Issue a request that is abandoned at cycle at_cyc after accept, by kill or by reset.
  task automatic run_abort(input logic op, input logic [31:0] a, input logic [31:0] b,
                           input int at_cyc, input bit use_reset);
    bus.rsp_ready = 1'b1;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 1; i < at_cyc; i++) begin
      @(posedge clk); #1;
    end
    if (!use_reset) begin
      bus.kill = 1'b1;
      @(posedge clk); #1;
      bus.kill = 1'b0;
      check("kill_to_idle", bus.req_ready, 1);
      check("kill_no_valid", bus.rsp_valid, 0);
    end else begin
      check("pre_reset_cell_en", bus.cell_en, 1);
      reset_n = 1'b0;
      #1;
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_cell_en", bus.cell_en, 0);
      check("rst_src1", bus.cell_src1, 0);
      check("rst_src2", bus.cell_src2, 0);
      check("rst_req_ready", bus.req_ready, 0);
      @(posedge clk); #2;
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("rst_release_ready", bus.req_ready, 1);
    end
    for (int i = 0; i < 6; i++) begin
      check("abort_silent", bus.rsp_valid, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] corners [4];
    logic [31:0] ra;
    logic [31:0] rb;
    total = 0;
    bad = 0;
    en_total = 0;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h0000_FFFF;
    corners[3] = 32'hFFFF_0000;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_a     = 32'h0;
    bus.req_b     = 32'h0;
    bus.kill      = 1'b0;
    bus.rsp_ready = 1'b1;
    #2;
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_data", bus.rsp_data, 0);
    check("reset_cell_en", bus.cell_en, 0);
    check("reset_src1", bus.cell_src1, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    check("reset_req_ready", bus.req_ready, 1);

    run_req(1'b0, 32'h0001_0002, 32'h0003_0004, 0, 1'b0);
    run_req(1'b1, 32'h0001_0002, 32'h0003_0004, 0, 1'b0);
    run_req(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_req(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_req(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 4, 1'b0);
    run_req(1'b0, 32'h0000_0005, 32'h0000_0009, 0, 1'b0);

    run_abort(1'b1, 32'hAAAA_5555, 32'h5555_AAAA, 2, 1'b0);
    run_req(1'b0, 32'd7, 32'd6, 0, 1'b0);
    run_req(1'b1, 32'h8000_0001, 32'h0000_0003, 0, 1'b1);
    run_abort(1'b0, 32'h0000_0011, 32'h0000_0022, 3, 1'b0);
    run_abort(1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF, 3, 1'b0);
    run_abort(1'b1, 32'hDEAD_BEEF, 32'h1357_9BDF, 3, 1'b1);
    run_req(1'b1, 32'hFFFF_0001, 32'h0001_FFFF, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      run_req(1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 2), 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule

// File: doc/nios_mul_sequencer.md
NIOS_MUL_SEQUENCER -- requirements
Module: nios_mul_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: req_valid  in  1  request offered.
REQ-004 SHALL have ports: req_ready  out  1  sequencer accepts request.
REQ-005 SHALL have ports: req_op  in  1  0 = MUL (low word), 1 = MULXUU (high word, unsigned).
REQ-006 SHALL have ports: req_a, req_b  in  32  operands.
REQ-007 SHALL have ports: kill  in  1  synchronous abort of in-flight operation.
REQ-008 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  32  result word.
REQ-009 SHALL have ports: cell_src1, cell_src2  out  32  operands driven to the 16x16 multiplier cell.
REQ-010 SHALL have ports: cell_en  out  1  cell register enable.
REQ-011 SHALL have ports: cell_p1, cell_p2, cell_p3  in  32  cell products (lo*lo, a_lo*b_hi, a_hi*b_lo), registered, 1-cycle latency after cell_en.

Function
REQ-012 SHALL implement FSM states IDLE, PASS1, CAP1, PASS2, CAP2, DONE.
REQ-013 SHALL assert req_ready only in IDLE; handshake fires on req_valid & req_ready, latching req_a, req_b, req_op; IDLE -> PASS1.
REQ-014 PASS1 SHALL drive cell_src1 = a, cell_src2 = b, cell_en = 1 for exactly one cycle; PASS1 -> CAP1.
REQ-015 CAP1 SHALL capture LL = cell_p1, LH = cell_p2, HL = cell_p3; op 0 -> DONE, op 1 -> PASS2.
REQ-016 PASS2 SHALL drive cell_src1 = {16'h0, a[31:16]}, cell_src2 = {16'h0, b[31:16]}, cell_en = 1 for one cycle; PASS2 -> CAP2.
REQ-017 CAP2 SHALL capture HH = cell_p1; CAP2 -> DONE.
REQ-018 cell_en SHALL be 0 in all states other than PASS1/PASS2; cell_src* SHALL hold their last value otherwise.
REQ-019 Result SHALL be P = {HH,LL} + ((LH + HL) << 16), computed at 64 bits with the 33-bit LH+HL carry preserved; rsp_data = P[31:0] for op 0, P[63:32] for op 1.
REQ-020 For op 0, the low word SHALL NOT depend on HH; PASS2/CAP2 SHALL be skipped.
REQ-021 DONE SHALL hold rsp_valid = 1 with stable rsp_data until rsp_ready; on rsp_valid & rsp_ready -> IDLE. New requests SHALL NOT be accepted in the same cycle (req_ready rises the following cycle).
REQ-022 Latency, acceptance edge to rsp_valid: 3 cycles (op 0), 5 cycles (op 1), with zero backpressure.
REQ-023 kill = 1 in any non-IDLE state SHALL force IDLE next cycle, drop rsp_valid, and produce no response; kill in IDLE SHALL be ignored; kill takes priority over rsp_ready in DONE.
REQ-024 kill coincident with a PASS state SHALL still allow that cycle's cell_en (harmless), but captured products SHALL be discarded.

Reset
REQ-025 On reset_n = 0, asynchronously: state = IDLE, rsp_valid = 0, rsp_data = 0, cell_en = 0, cell_src1/src2 = 0, latched operands/partials = 0; req_ready = 1 after deassertion.
REQ-026 Reset mid-operation SHALL abandon the operation with no response.

Structure
REQ-027 A shared package nios_mul_pkg SHALL hold the state enum, op encodings (OP_MUL = 0, OP_MULXUU = 1), and CELL_LATENCY = 1.
REQ-028 The 64-bit combine SHALL live in one combinational sub-module nios_mul_combine (inputs LL, LH, HL, HH; output P[63:0]); the multiplier cell stays external.

Verification
REQ-029 SHALL cover: MUL a = 0x00010002, b = 0x00030004 -> cell_en pulses once, rsp_data = 0x000A0008, rsp_valid 3 cycles after accept.
REQ-030 SHALL cover: MULXUU same operands -> two cell_en pulses, rsp_data = 0x00000003 at 5 cycles.
REQ-031 SHALL cover: MULXUU a = b = 0xFFFFFFFF -> rsp_data = 0xFFFFFFFE; MUL -> 0x00000001 (mid-sum carry exercised).
REQ-032 SHALL cover: rsp_ready held 0 for 4 cycles in DONE -> rsp_valid/rsp_data stable, req_ready = 0 throughout; accept next request 1 cycle after release.
REQ-033 SHALL cover: kill during CAP1 of MULXUU -> IDLE next cycle, no rsp_valid; following MUL 7 x 6 -> rsp_data = 42.
REQ-034 SHALL cover: reset_n pulsed low during PASS2 -> all outputs 0 immediately, req_ready = 1 after release, no stale response.
